loop_scheduler: RTL and testbench
=================================

# loop_scheduler

Nested-loop issue sequencer for the vector datapath. It latches an outer trip count (rows) and an inner trip count (cols) on `start`. It then issues one (i, j) index pair per accepted beat, using a valid/ready handshake, to the MULF/SUMF execution stage. It replaces per-iteration INCRI/INCRJ/SETN instruction traffic with a single hardware-sequenced loop and reports completion, abort and configuration errors to the ID-stage control.

## Interface
Parameters:
- `W`, default 32: width of trip counts, indices and beat counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous active-low reset (active when 0, sampled on `clk` rising edge).
- `start`  in  1  launch request; sampled only in IDLE.
- `abort`  in  1  cancel the running loop; sampled only in RUN.
- `n_rows`  in  W  outer trip count; latched on accepted `start`.
- `n_cols`  in  W  inner trip count; latched on accepted `start`.
- `issue_valid`  out  1  current (i, j) beat is valid.
- `issue_ready`  in  1  consumer accepts the beat this cycle.
- `i_idx`  out  W  outer index of current beat.
- `j_idx`  out  W  inner index of current beat.
- `row_end`  out  1  current beat has j_idx == cols-1.
- `last`  out  1  current beat is the final beat (i == rows-1 and j == cols-1).
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse after the final beat is accepted.
- `err_zero`  out  1  one-cycle pulse when `start` is accepted with a zero count.
- `beat_cnt`  out  W  number of beats accepted in the current or most recent run; wraps modulo 2^W.

## Operation
- FSM has three states: IDLE, RUN and DONE. All outputs are registered.
- Reset (`rst`==0 at an edge): state goes to IDLE. `i_idx`, `j_idx`, `beat_cnt`, the latched counts and every output are set to 0. Reset overrides all other inputs.
- IDLE:
  - `start`==1 with `n_rows`!=0 and `n_cols`!=0: latch rows/cols, clear i, j and `beat_cnt`, go to RUN.
  - `start`==1 with either count equal to 0: pulse `err_zero` for one cycle, stay in IDLE, leave `beat_cnt` untouched.
- RUN: `issue_valid`=1. A handshake is `issue_valid & issue_ready`. On each handshake:
  - `beat_cnt` increments.
  - If j == cols-1: j becomes 0 and i increments. Otherwise j increments.
  - If the accepted beat had `last`=1: go to DONE. i and j hold their final values and are not advanced.
- With no handshake, `i_idx`, `j_idx`, `row_end` and `last` hold stable.
- `abort`==1 in RUN: go to IDLE next cycle, with no `done` pulse and `issue_valid` deasserted.
  - Abort has priority over state advance. A handshake in the abort cycle still counts in `beat_cnt`, because the consumer took the beat.
- DONE: `issue_valid`=0 and `done`=1 for exactly one cycle, then IDLE.
- `start` in RUN or DONE is ignored. Changes on `n_rows`/`n_cols` after latch have no effect.
- `row_end` and `last` are combinational decodes of registered i, j and the latched counts. They are valid only while `issue_valid`=1 and are 0 otherwise.
- Index compare uses full W-bit equality. A count of 2^W-1 is legal; no internal overflow occurs because i < rows and j < cols.

## Timing
- `start` accepted at edge k: `issue_valid`=1 and (0,0) presented from cycle k+1.
- Throughput is 1 beat/cycle with `issue_ready` held high.
- Final handshake at edge t: `done`=1 during cycle t+1, `busy`=0 and state IDLE from cycle t+2.
- A run of rows×cols beats with no stall spans rows×cols+1 cycles of `busy`.
- `err_zero` is high in cycle k+1 only.
- The earliest accepted re-`start` is at the edge ending the first IDLE cycle after DONE.
- Reset mid-run: at the next edge every output is 0, with no `done` and no `err_zero`.

## Test plan
- **Basic run, rows=2, cols=3, ready always 1:** beats are (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). `row_end` is set on j=2 only. `last` is set on (1,2) only. `done` pulses 1 cycle after the last handshake. `beat_cnt`=6.
- **Backpressure, rows=1, cols=4, ready pattern 1,0,0,1,0,1,1:** indices hold during ready=0. Accepted sequence j=0,1,2,3. `done` pulses once. No beat is skipped or duplicated.
- **Zero count, start with n_cols=0:** `err_zero` pulses one cycle. `issue_valid` stays 0. `busy` stays 0. `done` never asserts.
- **Abort in the cycle of the 3rd handshake, rows=2, cols=2:** `beat_cnt`=3. IDLE next cycle. `issue_valid`=0. No `done` pulse. A subsequent start runs a fresh (0,0) sequence.
- **Reset mid-run (rst=0 for one edge at beat 2 of rows=3, cols=3):** all outputs are 0 at the next cycle. `start` then rows=1, cols=1 produces a single beat (0,0) with `row_end`=`last`=1, then `done`.
- **Start ignored while busy:** assert `start` with new counts during RUN. The running loop completes with the original counts.

Source files
------------

// File: rtl/loop_scheduler.sv
// loop_scheduler: hardware nested-loop sequencer. Latches rows/cols on start,
// then issues one (i, j) index pair per accepted valid/ready beat, row-major.
//
// Handshake: issue_valid is high for the whole RUN state. It is independent of
// issue_ready. A beat transfers on any rising edge where issue_valid and
// issue_ready are both high. While no transfer happens, the indices and their
// decodes hold stable.
module loop_scheduler #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] n_rows,
    input  logic [W-1:0] n_cols,
    output logic         issue_valid,
    input  logic         issue_ready,
    output logic [W-1:0] i_idx,
    output logic [W-1:0] j_idx,
    output logic         row_end,
    output logic         last,
    output logic         busy,
    output logic         done,
    output logic         err_zero,
    output logic [W-1:0] beat_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [W-1:0] rows_q;
    logic [W-1:0] cols_q;
    logic [W-1:0] i_q;
    logic [W-1:0] j_q;
    logic [W-1:0] beat_q;
    logic         err_q;

    logic hs;
    logic start_ok;
    logic start_bad;
    logic at_row_end;
    logic at_last;

    // A zero count would make the loop empty, so it is rejected instead of launched.
    assign start_ok   = start && (n_rows != '0) && (n_cols != '0);
    assign start_bad  = start && ((n_rows == '0) || (n_cols == '0));
    assign hs         = (state == RUN) && issue_ready;
    // Full-width equality on registered indices. i < rows and j < cols always hold.
    assign at_row_end = (j_q == cols_q - W'(1));
    assign at_last    = at_row_end && (i_q == rows_q - W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Abort wins over completion in RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_ok) state_next = RUN;
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (hs && at_last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Index, count and error registers. A beat taken in the abort cycle still counts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rows_q <= '0;
            cols_q <= '0;
            i_q    <= '0;
            j_q    <= '0;
            beat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        rows_q <= n_rows;
                        cols_q <= n_cols;
                        i_q    <= '0;
                        j_q    <= '0;
                        beat_q <= '0;
                    end else if (start_bad) begin
                        err_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (hs) begin
                        beat_q <= beat_q + W'(1);
                        // The final beat leaves i/j on their last values.
                        if (!at_last) begin
                            if (at_row_end) begin
                                j_q <= '0;
                                i_q <= i_q + W'(1);
                            end else begin
                                j_q <= j_q + W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from registered state, indices and latched counts.
    always_comb begin
        issue_valid = (state == RUN);
        busy        = (state != IDLE);
        done        = (state == DONE);
        row_end     = (state == RUN) && at_row_end;
        last        = (state == RUN) && at_last;
        err_zero    = err_q;
        i_idx       = i_q;
        j_idx       = j_q;
        beat_cnt    = beat_q;
    end

endmodule

// File: tb/tb_loop_scheduler.sv
// tb_loop_scheduler: the bench pushes the expected beats {last, row_end, i, j}
// when it launches a run. A negedge monitor pops one entry and compares it on
// every handshake.
module tb_loop_scheduler;

    localparam int W  = 8;
    localparam int EW = 2 + 2 * W;

    logic         clk;
    logic         rst;
    logic         start;
    logic         abort;
    logic [W-1:0] n_rows;
    logic [W-1:0] n_cols;
    logic         issue_valid;
    logic         issue_ready;
    logic [W-1:0] i_idx;
    logic [W-1:0] j_idx;
    logic         row_end;
    logic         last;
    logic         busy;
    logic         done;
    logic         err_zero;
    logic [W-1:0] beat_cnt;

    logic [EW-1:0] exp_q[$];
    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    loop_scheduler #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .n_rows(n_rows), .n_cols(n_cols),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .i_idx(i_idx), .j_idx(j_idx), .row_end(row_end), .last(last),
        .busy(busy), .done(done), .err_zero(err_zero), .beat_cnt(beat_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    // Sampling point: 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int r, input int c);
        logic          le;
        logic          re;
        logic [EW-1:0] e;
        for (int i = 0; i < r; i++) begin
            for (int j = 0; j < c; j++) begin
                re = (j == c - 1);
                le = re && (i == r - 1);
                e  = {le, re, W'(i), W'(j)};
                exp_q.push_back(e);
            end
        end
    endtask

    // The caller must be in IDLE. The task returns in the first cycle after start is sampled.
    task automatic start_run(input int r, input int c);
        start  = 1'b1;
        n_rows = W'(r);
        n_cols = W'(c);
        if (r != 0 && c != 0) push_run(r, c);
        step();
        start  = 1'b0;
        n_rows = $urandom_range(0, 255);
        n_cols = $urandom_range(0, 255);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        logic seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            if (done) seen = 1'b1;
            else begin
                step();
                cycles++;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {11'd0, issue_valid, row_end, last, busy, done, err_zero, i_idx, j_idx, beat_cnt}, 32'd0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst && issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                check("beat_unexpected", {14'd0, last, row_end, i_idx, j_idx}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("beat", {14'd0, last, row_end, i_idx, j_idx}, 32'(e));
            end
        end
        if (rst && done) done_cnt++;
        if (rst && err_zero) err_cnt++;
    end

    initial begin
        int cyc;
        int d0;
        int e0;
        int r;
        int c;
        logic [W-1:0] b0;
        logic bp_pat[7];
        bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst = 1'b0; start = 1'b0; abort = 1'b0;
        n_rows = '0; n_cols = '0; issue_ready = 1'b0;
        step(); step();
        rst = 1'b1;
        check_all_zero("reset_outputs");
        issue_ready = 1'b1;

        // Basic 2x3 run at full throughput
        start_run(2, 3);
        check("basic_valid", 32'(issue_valid), 32'd1);
        check("basic_busy", 32'(busy), 32'd1);
        d0 = done_cnt;
        wait_done(50, cyc);
        check("basic_run_cycles", cyc, 32'd6);
        check("basic_beat_cnt", 32'(beat_cnt), 32'd6);
        check("basic_done_valid", 32'(issue_valid), 32'd0);
        step();
        check("basic_idle_busy", 32'(busy), 32'd0);
        check("basic_done_once", done_cnt - d0, 32'd1);
        check("basic_queue_empty", exp_q.size(), 32'd0);

        // Backpressure 1x4 with a fixed ready pattern
        issue_ready = 1'b0;
        start_run(1, 4);
        d0 = done_cnt;
        for (int p = 0; p < 7; p++) begin
            issue_ready = bp_pat[p];
            step();
        end
        issue_ready = 1'b1;
        check("bp_done", 32'(done), 32'd1);
        check("bp_beat_cnt", 32'(beat_cnt), 32'd4);
        check("bp_queue_empty", exp_q.size(), 32'd0);
        step(); step();
        check("bp_done_once", done_cnt - d0, 32'd1);

        // A zero count is rejected without touching beat_cnt
        b0 = beat_cnt; d0 = done_cnt; e0 = err_cnt;
        start_run(3, 0);
        check("zero_err", 32'(err_zero), 32'd1);
        check("zero_valid", 32'(issue_valid), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);
        step();
        check("zero_err_clear", 32'(err_zero), 32'd0);
        check("zero_busy2", 32'(busy), 32'd0);
        check("zero_beat_cnt", 32'(beat_cnt), 32'(b0));
        step(); step();
        check("zero_err_once", err_cnt - e0, 32'd1);
        check("zero_no_done", done_cnt - d0, 32'd0);

        // Abort in the cycle of the 3rd handshake on a 2x2 run
        d0 = done_cnt;
        start_run(2, 2);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_beat_cnt", 32'(beat_cnt), 32'd3);
        check("abort_valid", 32'(issue_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_queue_left", exp_q.size(), 32'd1);
        exp_q.delete();
        step(); step();
        check("abort_no_done", done_cnt - d0, 32'd0);
        start_run(1, 2);
        wait_done(20, cyc);
        check("abort_rerun_cnt", 32'(beat_cnt), 32'd2);
        step();

        // Reset in the middle of a 3x3 run
        d0 = done_cnt; e0 = err_cnt;
        start_run(3, 3);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_all_zero("midreset_outputs");
        exp_q.delete();
        step();
        check("midreset_no_done", done_cnt - d0, 32'd0);
        check("midreset_no_err", err_cnt - e0, 32'd0);
        start_run(1, 1);
        check("one_row_end", 32'(row_end), 32'd1);
        check("one_last", 32'(last), 32'd1);
        wait_done(10, cyc);
        check("one_cycles", cyc, 32'd1);
        check("one_beat_cnt", 32'(beat_cnt), 32'd1);
        step();

        // Start while busy is ignored
        start_run(2, 2);
        step();
        start = 1'b1; n_rows = 8'd5; n_cols = 8'd5;
        step();
        start = 1'b0;
        wait_done(50, cyc);
        check("ign_beat_cnt", 32'(beat_cnt), 32'd4);
        step();
        check("ign_busy", 32'(busy), 32'd0);
        check("ign_queue_empty", exp_q.size(), 32'd0);

        // Random runs with random backpressure
        for (int t = 0; t < 4; t++) begin
            r = $urandom_range(1, 4);
            c = $urandom_range(1, 4);
            start_run(r, c);
            cyc = 0;
            while (!done && cyc < 400) begin
                issue_ready = ($urandom_range(0, 3) != 0);
                step();
                cyc++;
            end
            issue_ready = 1'b1;
            check("rand_done", 32'(done), 32'd1);
            check("rand_beat_cnt", 32'(beat_cnt), 32'(r * c));
            step();
        end
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
